data_mem_sync: RTL and testbench

DATA_MEM_SYNC -- requirements
Module: data_mem_sync

---
 rtl/data_mem_sync.sv | 102 ++++++++++
 tb/tb_data_mem_sync.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/data_mem_sync.sv
// Single-port data memory with a one-cycle registered response. After reset it can
// zero every word, one word per cycle, before it accepts any request.
module data_mem_sync #(
  parameter int DATA_W         = 32,
  parameter int DEPTH          = 64,
  parameter int ADDR_W         = 32,
  parameter int BYTE_ADDR      = 1,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_we,
  input  logic [ADDR_W-1:0]   req_addr,
  input  logic [DATA_W-1:0]   req_wdata,
  input  logic [DATA_W/8-1:0] req_be,
  output logic                rsp_valid,
  output logic [DATA_W-1:0]   rsp_rdata,
  output logic                rsp_err,
  output logic                init_done,
  output logic [0:0]          dbg_state
);

  // Handshake: a request transfers on a rising edge where req_valid && req_ready.
  // Its response is rsp_valid for exactly the following cycle, with no backpressure.

  localparam int NB    = DATA_W / 8;
  localparam int LSB   = (BYTE_ADDR != 0) ? $clog2(NB) : 0;
  localparam int IDX_W = $clog2(DEPTH);
  localparam int CMP_W = (ADDR_W > 32) ? ADDR_W : 32;

  localparam logic [ADDR_W-1:0] LSB_MASK = ADDR_W'((64'd1 << LSB) - 64'd1);
  localparam logic [CMP_W-1:0]  DEPTH_C  = CMP_W'(DEPTH);
  localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(DEPTH - 1);

  localparam logic [0:0] S_CLEAR = 1'b0;
  localparam logic [0:0] S_IDLE  = 1'b1;
  localparam logic [0:0] S_RESET = (CLEAR_ON_RESET != 0) ? S_CLEAR : S_IDLE;

  logic [0:0]        state;
  logic [IDX_W-1:0]  clr_idx;
  logic [DATA_W-1:0] mem [DEPTH];

  logic [ADDR_W-1:0] word_idx;
  logic [IDX_W-1:0]  mem_idx;
  logic              misaligned;
  logic              out_of_range;
  logic              req_err;
  logic              accept;

  // Range check is done on the full-width index so high address bits never alias.
  assign word_idx     = req_addr >> LSB;
  assign mem_idx      = word_idx[IDX_W-1:0];
  assign misaligned   = (req_addr & LSB_MASK) != '0;
  assign out_of_range = CMP_W'(word_idx) >= DEPTH_C;
  assign req_err      = misaligned || out_of_range;

  // Gated by rst_n so ready stays low during reset even when the clear pass is skipped.
  assign req_ready = rst_n && (state == S_IDLE);
  assign init_done = req_ready;
  assign accept    = req_valid && req_ready;
  assign dbg_state = state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_RESET;
      clr_idx <= '0;
    end else if (state == S_CLEAR) begin
      if (clr_idx == LAST_IDX) begin
        state <= S_IDLE;
      end
      clr_idx <= clr_idx + 1'b1;
    end
  end

  // No reset on the array so it maps onto synchronous-write RAM.
  always_ff @(posedge clk) begin
    if (state == S_CLEAR) begin
      mem[clr_idx] <= '0;
    end else if (accept && req_we && !req_err) begin
      for (int i = 0; i < NB; i++) begin
        if (req_be[i]) begin
          mem[mem_idx][8*i +: 8] <= req_wdata[8*i +: 8];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid <= 1'b0;
      rsp_err   <= 1'b0;
      rsp_rdata <= '0;
    end else begin
      rsp_valid <= accept;
      rsp_err   <= accept && req_err;
      rsp_rdata <= (accept && !req_we && !req_err) ? mem[mem_idx] : '0;
    end
  end

endmodule

// File: tb/tb_data_mem_sync.sv
// Bench for data_mem_sync at default parameters: vector table, back-to-back traffic,
// and reset aborting a pending response and a clear pass in progress.
module tb_data_mem_sync;

  localparam int DEPTH = 64;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic        exp_err;
    logic [31:0] exp_rdata;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic [3:0]  req_be = '0;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        init_done;
  logic [0:0]  dbg_state;

  int n_cmp = 0;
  int n_err = 0;

  logic [32:0] exp_q[$];
  logic [31:0] mem_m [DEPTH];
  logic        ready_m = 1'b0;
  logic        due = 1'b0;
  int          cyc = 0;

  vec_t vecs[$];

  data_mem_sync dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_we    (req_we),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .req_be    (req_be),
    .rsp_valid (rsp_valid),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err),
    .init_done (init_done),
    .dbg_state (dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial rst_n = 1'b0;

  // Reference timing: ready rises DEPTH edges after release; a response is due the
  // cycle after any edge that saw req_valid while ready.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      due     = 1'b0;
      cyc     = 0;
      ready_m = 1'b0;
      exp_q.delete();
      for (int i = 0; i < DEPTH; i++) mem_m[i] = '0;
    end else begin
      due = req_valid && ready_m;
      if (!ready_m) begin
        cyc++;
        if (cyc == DEPTH) ready_m = 1'b1;
      end
    end
  end

  // ---------------- checking ----------------
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    logic [32:0] e;
    chk("req_ready", 64'(req_ready), 64'(ready_m));
    chk("init_done", 64'(init_done), 64'(ready_m));
    chk("rsp_valid", 64'(rsp_valid), 64'(due));
    if (!rsp_valid) begin
      chk("idle_rsp_err", 64'(rsp_err), 64'd0);
      chk("idle_rsp_rdata", 64'(rsp_rdata), 64'd0);
    end
    if (due) begin
      if (exp_q.size() == 0) begin
        chk("scoreboard_underflow", 64'(exp_q.size()), 64'd1);
      end else begin
        e = exp_q.pop_front();
        chk("rsp_err", 64'(rsp_err), 64'(e[32]));
        chk("rsp_rdata", 64'(rsp_rdata), 64'(e[31:0]));
      end
    end
  end

  // ---------------- driver ----------------
  // Called #1 after a rising edge; leaves the request up for exactly one edge.
  task automatic drive_req(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                           input logic [3:0] be, input logic use_exp,
                           input logic exp_err, input logic [31:0] exp_rdata);
    logic        err;
    logic [31:0] rd;
    int          idx;
    req_valid = 1'b1;
    req_we    = we;
    req_addr  = addr;
    req_wdata = wdata;
    req_be    = be;
    err = (addr[1:0] != 2'b00) || ((addr >> 2) >= 32'(DEPTH));
    idx = int'(addr >> 2);
    rd  = '0;
    if (!we && !err) rd = mem_m[idx];
    if (ready_m) begin
      exp_q.push_back(use_exp ? {exp_err, exp_rdata} : {err, rd});
      if (we && !err) begin
        for (int b = 0; b < 4; b++) begin
          if (be[b]) mem_m[idx][8*b +: 8] = wdata[8*b +: 8];
        end
      end
    end
    @(posedge clk);
    #1;
    req_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    req_valid = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_ready();
    for (int i = 0; i < 200; i++) begin
      if (req_ready) break;
      @(posedge clk);
      #1;
    end
    chk("ready_wait", 64'(req_ready), 64'd1);
  endtask

  function automatic void add_vec(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                                  input logic [3:0] be, input logic exp_err, input logic [31:0] exp_rdata);
    vec_t v;
    v.we = we; v.addr = addr; v.wdata = wdata; v.be = be;
    v.exp_err = exp_err; v.exp_rdata = exp_rdata;
    vecs.push_back(v);
  endfunction

  // ---------------- test ----------------
  initial begin
    //        we    addr           wdata          be       err   rdata
    add_vec(1'b0, 32'h0000_00FC, 32'h0,         4'b0000, 1'b0, 32'h0000_0000);
    add_vec(1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 4'b1111, 1'b0, 32'h0000_0000);
    add_vec(1'b0, 32'h0000_0010, 32'h0,         4'b0000, 1'b0, 32'hDEAD_BEEF);
    add_vec(1'b1, 32'h0000_0020, 32'h1122_3344, 4'b1111, 1'b0, 32'h0000_0000);
    add_vec(1'b1, 32'h0000_0020, 32'hAABB_CCDD, 4'b0101, 1'b0, 32'h0000_0000);
    add_vec(1'b0, 32'h0000_0020, 32'h0,         4'b0000, 1'b0, 32'h11BB_33DD);
    add_vec(1'b0, 32'h0000_0002, 32'h0,         4'b0000, 1'b1, 32'h0000_0000);
    add_vec(1'b1, 32'h0000_0100, 32'h1234_5678, 4'b1111, 1'b1, 32'h0000_0000);
    add_vec(1'b1, 32'h0000_0002, 32'h1234_5678, 4'b1111, 1'b1, 32'h0000_0000);
    add_vec(1'b0, 32'h0000_0000, 32'h0,         4'b0000, 1'b0, 32'h0000_0000);
    add_vec(1'b0, 32'h0000_0010, 32'h0,         4'b0000, 1'b0, 32'hDEAD_BEEF);
    add_vec(1'b1, 32'h0000_0024, 32'hCAFE_F00D, 4'b0000, 1'b0, 32'h0000_0000);
    add_vec(1'b0, 32'h0000_0024, 32'h0,         4'b0000, 1'b0, 32'h0000_0000);
    add_vec(1'b1, 32'h0000_00FC, 32'h0A0B_0C0D, 4'b1111, 1'b0, 32'h0000_0000);
    add_vec(1'b0, 32'h0000_00FC, 32'h0,         4'b0000, 1'b0, 32'h0A0B_0C0D);
    add_vec(1'b0, 32'hFFFF_FFFC, 32'h0,         4'b0000, 1'b1, 32'h0000_0000);
    add_vec(1'b0, 32'h0000_0104, 32'h0,         4'b0000, 1'b1, 32'h0000_0000);
    add_vec(1'b1, 32'h0000_0004, 32'h5566_7788, 4'b1000, 1'b0, 32'h0000_0000);
    add_vec(1'b0, 32'h0000_0004, 32'h0,         4'b0000, 1'b0, 32'h5500_0000);

    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    wait_ready();

    // Table vectors issued back to back, one per cycle.
    foreach (vecs[i]) begin
      drive_req(vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].be,
                1'b1, vecs[i].exp_err, vecs[i].exp_rdata);
    end
    idle(2);

    // Alternating write/read pairs, no gaps.
    for (int i = 0; i < 4; i++) begin
      logic [31:0] a;
      a = 32'($urandom_range(0, DEPTH - 1)) << 2;
      drive_req(1'b1, a, $urandom, 4'($urandom_range(0, 15)), 1'b0, 1'b0, 32'h0);
      drive_req(1'b0, a, 32'h0, 4'b0000, 1'b0, 1'b0, 32'h0);
    end
    idle(2);

    // Reset right after a read is accepted: its response must be dropped.
    drive_req(1'b0, 32'h0000_0010, 32'h0, 4'b0000, 1'b0, 1'b0, 32'h0);
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Requests during clear are ignored; reset at clear index 30 restarts the pass.
    req_valid = 1'b1;
    req_we    = 1'b0;
    req_addr  = 32'h0000_0010;
    repeat (30) @(posedge clk);
    #1;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (40) @(posedge clk);
    #1;
    req_valid = 1'b0;
    wait_ready();

    drive_req(1'b0, 32'h0000_0010, 32'h0, 4'b0000, 1'b1, 1'b0, 32'h0000_0000);
    drive_req(1'b0, 32'h0000_00FC, 32'h0, 4'b0000, 1'b1, 1'b0, 32'h0000_0000);
    drive_req(1'b1, 32'h0000_0008, 32'h0102_0304, 4'b0011, 1'b1, 1'b0, 32'h0000_0000);
    drive_req(1'b0, 32'h0000_0008, 32'h0, 4'b0000, 1'b1, 1'b0, 32'h0000_0304);
    idle(3);

    chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
